mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDRBITS, default 32, address width.
REQ-002 SHALL have parameter DATABITS, default 32, data width.
REQ-003 SHALL have parameter TOBITS, default 8, timeout counter width.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports dc_addr/dc_wdata  input  ADDRBITS/DATABITS  dcache-side request address and write data.
REQ-007 SHALL have ports dc_rdreq, dc_wrreq  input  1  dcache request, level, held until dc_valid.
REQ-008 SHALL have ports dc_rdata  output  DATABITS, dc_valid  output  1  dcache response.
REQ-009 SHALL have ports ic_addr  input  ADDRBITS, ic_rdreq  input  1, ic_rdata  output  DATABITS, ic_valid  output  1  icache read-only client.
REQ-010 SHALL have ports ctl_addr  output  ADDRBITS, ctl_wdata  output  DATABITS, ctl_rdreq/ctl_wrreq  output  1  memory-controller request.
REQ-011 SHALL have ports ctl_rdata  input  DATABITS, ctl_valid  input  1  memory-controller single-cycle completion.
REQ-012 SHALL have port err_timeout  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, BUSY, RESP.
REQ-014 IDLE: a pending request at cycle N SHALL latch owner, addr, wdata, req type; ctl_* asserted from cycle N+1 (registered), state->BUSY.
REQ-015 Both clients requesting in IDLE SHALL resolve round-robin: grant the client not granted last; after reset dcache wins first.
REQ-016 dc_rdreq and dc_wrreq both high SHALL be treated as write.
REQ-017 BUSY: ctl_addr/ctl_wdata/ctl_*req SHALL hold stable until ctl_valid sampled high.
REQ-018 On ctl_valid at cycle V: ctl_*req SHALL drop at V+1; owner's *_valid SHALL be high for exactly cycle V+1 with *_rdata = ctl_rdata captured at V; state->RESP.
REQ-019 Writes SHALL also produce the one-cycle *_valid; *_rdata for writes SHALL be 0.
REQ-020 RESP: one cycle, new requests ignored (client drops request on its valid), then ->IDLE.
REQ-021 Non-owner *_valid SHALL stay 0; *_rdata of non-owner SHALL hold previous value.
REQ-022 ctl_valid in IDLE or RESP SHALL be ignored.
REQ-023 BUSY timeout counter SHALL clear on entry, increment per cycle, saturate at 2^TOBITS-1; reaching it sets err_timeout (sticky) without aborting the transaction.
REQ-024 Client requests changing address while BUSY SHALL not affect ctl_addr (latched copy used).

Reset
REQ-025 Reset SHALL force state IDLE, last-grant = icache (so dcache wins first), all outputs 0, timeout counter 0, err_timeout 0.
REQ-026 Reset asserted mid-BUSY SHALL drop ctl_*req asynchronously; no *_valid SHALL be generated for the aborted transaction.

Structure
REQ-027 State encoding and ADDRBITS/DATABITS defaults SHALL live in the shared cache package used by icache/dcache.
REQ-028 SHALL be a single module; no sub-modules.

Verification
REQ-029 dc_rdreq=1, dc_addr=0x100 at cycle 0; controller returns 0xDEADBEEF with ctl_valid at cycle 4 -> ctl_rdreq 1..4, dc_valid=1 at cycle 5 only, dc_rdata=0xDEADBEEF.
REQ-030 dc_rdreq and ic_rdreq both high after reset -> dcache served first; next IDLE grants icache; third grant dcache.
REQ-031 dc_wrreq=1, addr 0x200, wdata 0x12345678 -> ctl_wrreq=1, ctl_wdata=0x12345678 held until ctl_valid; dc_valid one cycle, dc_rdata=0.
REQ-032 TOBITS=4, ctl_valid withheld 20 cycles -> err_timeout rises at BUSY cycle 15, stays 1; transaction completes normally at ctl_valid.
REQ-033 reset_n low in BUSY -> ctl_rdreq 0 immediately; after release no dc_valid/ic_valid pulse; spurious ctl_valid in IDLE ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_arbiter_pkg                                              |
// | Description : Shared cache-subsystem definitions used by the icache,       |
// |               the dcache and the memory arbiter: bus width defaults,       |
// |               the arbiter state encoding and the owner encoding.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int unsigned ADDRBITS_DEF = 32;
  localparam int unsigned DATABITS_DEF = 32;
  localparam int unsigned TOBITS_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_DC = 1'b0,
    OWN_IC = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Two-client (dcache read/write, icache read) arbiter in front |
// |               of a single memory controller. One outstanding transaction,  |
// |               round-robin grant, registered controller request, one-cycle |
// |               response pulse to the owner, sticky BUSY timeout flag.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset_n          clock (rising edge), async active-low reset        |
// |   dc_addr/dc_wdata      dcache request address / write data               |
// |   dc_rdreq/dc_wrreq     dcache request level (both high = write)          |
// |   dc_rdata/dc_valid     dcache response (valid is a one-cycle pulse)      |
// |   ic_addr/ic_rdreq      icache read request                               |
// |   ic_rdata/ic_valid     icache response                                   |
// |   ctl_addr/ctl_wdata    controller request address / write data          |
// |   ctl_rdreq/ctl_wrreq   controller request, held until ctl_valid          |
// |   ctl_rdata/ctl_valid   controller single-cycle completion                |
// |   err_timeout           sticky: BUSY lasted 2^TOBITS-1 cycles             |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDRBITS = ADDRBITS_DEF,
  parameter int unsigned DATABITS = DATABITS_DEF,
  parameter int unsigned TOBITS   = TOBITS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] dc_addr,
  input  logic [DATABITS-1:0] dc_wdata,
  input  logic                dc_rdreq,
  input  logic                dc_wrreq,
  output logic [DATABITS-1:0] dc_rdata,
  output logic                dc_valid,
  input  logic [ADDRBITS-1:0] ic_addr,
  input  logic                ic_rdreq,
  output logic [DATABITS-1:0] ic_rdata,
  output logic                ic_valid,
  output logic [ADDRBITS-1:0] ctl_addr,
  output logic [DATABITS-1:0] ctl_wdata,
  output logic                ctl_rdreq,
  output logic                ctl_wrreq,
  input  logic [DATABITS-1:0] ctl_rdata,
  input  logic                ctl_valid,
  output logic                err_timeout
);

  localparam logic [TOBITS-1:0] TO_MAX = '1;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                last_ic_q, last_ic_d;
  logic [ADDRBITS-1:0] ctl_addr_q, ctl_addr_d;
  logic [DATABITS-1:0] ctl_wdata_q, ctl_wdata_d;
  logic                ctl_rdreq_q, ctl_rdreq_d;
  logic                ctl_wrreq_q, ctl_wrreq_d;
  logic [DATABITS-1:0] dc_rdata_q, dc_rdata_d;
  logic                dc_valid_q, dc_valid_d;
  logic [DATABITS-1:0] ic_rdata_q, ic_rdata_d;
  logic                ic_valid_q, ic_valid_d;
  logic [TOBITS-1:0]   to_cnt_q, to_cnt_d;
  logic                err_q, err_d;

  logic                dc_req;
  logic                grant_ic;
  logic [DATABITS-1:0] resp_data;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_ic_d   = last_ic_q;
    ctl_addr_d  = ctl_addr_q;
    ctl_wdata_d = ctl_wdata_q;
    ctl_rdreq_d = ctl_rdreq_q;
    ctl_wrreq_d = ctl_wrreq_q;
    dc_rdata_d  = dc_rdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_valid_d  = 1'b0;
    ic_valid_d  = 1'b0;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;

    dc_req    = dc_rdreq | dc_wrreq;
    // icache wins when alone, or when both request and dcache had the last grant
    grant_ic  = ic_rdreq & (~dc_req | ~last_ic_q);
    // ctl_wrreq_q is still high in the completion cycle, so it tells us the type
    resp_data = ctl_wrreq_q ? '0 : ctl_rdata;

    case (state_q)
      ST_IDLE: begin
        if (dc_req || ic_rdreq) begin
          owner_d     = grant_ic ? OWN_IC : OWN_DC;
          last_ic_d   = grant_ic;
          ctl_addr_d  = grant_ic ? ic_addr : dc_addr;
          ctl_wdata_d = grant_ic ? '0 : dc_wdata;
          ctl_wrreq_d = ~grant_ic & dc_wrreq;
          ctl_rdreq_d = grant_ic | ~dc_wrreq;
          to_cnt_d    = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ctl_valid) begin
          ctl_rdreq_d = 1'b0;
          ctl_wrreq_d = 1'b0;
          state_d     = ST_RESP;
          if (owner_q == OWN_IC) begin
            ic_valid_d = 1'b1;
            ic_rdata_d = resp_data;
          end else begin
            dc_valid_d = 1'b1;
            dc_rdata_d = resp_data;
          end
        end else begin
          if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
          // flag only; the transaction keeps waiting for the controller
          if (to_cnt_d == TO_MAX) begin
            err_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_DC;
      last_ic_q   <= 1'b1;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      ctl_rdreq_q <= 1'b0;
      ctl_wrreq_q <= 1'b0;
      dc_rdata_q  <= '0;
      dc_valid_q  <= 1'b0;
      ic_rdata_q  <= '0;
      ic_valid_q  <= 1'b0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_ic_q   <= last_ic_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_wdata_q <= ctl_wdata_d;
      ctl_rdreq_q <= ctl_rdreq_d;
      ctl_wrreq_q <= ctl_wrreq_d;
      dc_rdata_q  <= dc_rdata_d;
      dc_valid_q  <= dc_valid_d;
      ic_rdata_q  <= ic_rdata_d;
      ic_valid_q  <= ic_valid_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

  assign ctl_addr    = ctl_addr_q;
  assign ctl_wdata   = ctl_wdata_q;
  assign ctl_rdreq   = ctl_rdreq_q;
  assign ctl_wrreq   = ctl_wrreq_q;
  assign dc_rdata    = dc_rdata_q;
  assign dc_valid    = dc_valid_q;
  assign ic_rdata    = ic_rdata_q;
  assign ic_valid    = ic_valid_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Self-checking bench for mem_arbiter: vector table of single  |
// |               transactions plus hand-written round-robin, timeout and     |
// |               mid-transaction reset sequences; responses checked through  |
// |               an expectation queue.                                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TOB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0;
  logic          dc_rdreq = 1'b0;
  logic          dc_wrreq = 1'b0;
  logic [DW-1:0] dc_rdata;
  logic          dc_valid;
  logic [AW-1:0] ic_addr = '0;
  logic          ic_rdreq = 1'b0;
  logic [DW-1:0] ic_rdata;
  logic          ic_valid;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_wdata;
  logic          ctl_rdreq;
  logic          ctl_wrreq;
  logic [DW-1:0] ctl_rdata = '0;
  logic          ctl_valid = 1'b0;
  logic          err_timeout;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDRBITS(AW),
    .DATABITS(DW),
    .TOBITS  (TOB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dc_addr    (dc_addr),
    .dc_wdata   (dc_wdata),
    .dc_rdreq   (dc_rdreq),
    .dc_wrreq   (dc_wrreq),
    .dc_rdata   (dc_rdata),
    .dc_valid   (dc_valid),
    .ic_addr    (ic_addr),
    .ic_rdreq   (ic_rdreq),
    .ic_rdata   (ic_rdata),
    .ic_valid   (ic_valid),
    .ctl_addr   (ctl_addr),
    .ctl_wdata  (ctl_wdata),
    .ctl_rdreq  (ctl_rdreq),
    .ctl_wrreq  (ctl_wrreq),
    .ctl_rdata  (ctl_rdata),
    .ctl_valid  (ctl_valid),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic          ic;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          ic;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    logic          extra;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] last_dc_rdata = '0;
  logic [DW-1:0] last_ic_rdata = '0;
  vec_t          vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation;
  // the client that did not own the transaction must keep its old rdata.
  task automatic monitor();
    exp_t e;
    if (reset_n && (dc_valid || ic_valid)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dc_valid=%0b ic_valid=%0b expected none", dc_valid, ic_valid);
      end else begin
        e = sb_q.pop_front();
        chk("resp_owner", {62'd0, dc_valid, ic_valid}, e.ic ? 64'd1 : 64'd2);
        if (e.ic) begin
          chk("ic_rdata", ic_rdata, e.data);
          chk("dc_rdata_hold", dc_rdata, last_dc_rdata);
          last_ic_rdata = e.data;
        end else begin
          chk("dc_rdata", dc_rdata, e.data);
          chk("ic_rdata_hold", ic_rdata, last_ic_rdata);
          last_dc_rdata = e.data;
        end
      end
    end
  endtask

  // Advance one cycle: sample at mid-cycle, then step to just after the edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    logic is_wr;
    logic stable;
    exp_t e;
    is_wr = !v.ic && v.wr;
    if (v.ic) begin
      ic_rdreq = 1'b1;
      ic_addr  = v.addr;
    end else begin
      dc_rdreq = v.rd;
      dc_wrreq = v.wr;
      dc_addr  = v.addr;
      dc_wdata = v.wdata;
    end
    e.ic   = v.ic;
    e.data = is_wr ? '0 : v.rdata;
    sb_q.push_back(e);
    tick();
    chk("txn_ctl_rdreq", {63'd0, ctl_rdreq}, {63'd0, !is_wr});
    chk("txn_ctl_wrreq", {63'd0, ctl_wrreq}, {63'd0, is_wr});
    chk("txn_ctl_addr", {32'd0, ctl_addr}, {32'd0, v.addr});
    if (is_wr) chk("txn_ctl_wdata", {32'd0, ctl_wdata}, {32'd0, v.wdata});
    // client lines wander while BUSY; the controller side must not follow
    dc_addr  = ~v.addr;
    ic_addr  = ~v.addr;
    dc_wdata = ~v.wdata;
    stable   = 1'b1;
    for (int k = 0; k < v.lat; k++) begin
      tick();
      if (ctl_addr !== v.addr || ctl_rdreq !== !is_wr || ctl_wrreq !== is_wr ||
          (is_wr && ctl_wdata !== v.wdata)) stable = 1'b0;
    end
    if (v.lat > 0) chk("txn_ctl_hold", {63'd0, stable}, 64'd1);
    ctl_valid = 1'b1;
    ctl_rdata = v.rdata;
    tick();
    if (!v.extra) ctl_valid = 1'b0;
    ctl_rdata = 32'hBAADBAAD;
    chk("txn_req_drop", {62'd0, ctl_rdreq, ctl_wrreq}, 64'd0);
    dc_rdreq = 1'b0;
    dc_wrreq = 1'b0;
    ic_rdreq = 1'b0;
    tick();
    ctl_valid = 1'b0;
    chk("txn_idle_quiet", {62'd0, ctl_rdreq, ctl_wrreq}, 64'd0);
  endtask

  initial begin
    logic       quiet;
    logic [2:0] rr_exp;
    exp_t       e;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0,         32'h1111_2222, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h5555_5555, 3, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'hCAFE_F00D, 2, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0BAD_C0DE, 32'hFFFF_FFFF, 1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0001, 5, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h5A5A_5A5A, 2, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl_req", {62'd0, ctl_rdreq, ctl_wrreq}, 64'd0);
    chk("rst_ctl_addr", {32'd0, ctl_addr}, 64'd0);
    chk("rst_ctl_wdata", {32'd0, ctl_wdata}, 64'd0);
    chk("rst_valids", {62'd0, dc_valid, ic_valid}, 64'd0);
    chk("rst_rdata", {dc_rdata, ic_rdata}, 64'd0);
    chk("rst_err", {63'd0, err_timeout}, 64'd0);
    reset_n = 1'b1;
    tick();

    // round robin from reset: dcache, icache, dcache
    rr_exp   = 3'b010;
    dc_addr  = 32'h10;
    ic_addr  = 32'h20;
    dc_rdreq = 1'b1;
    ic_rdreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.ic   = rr_exp[i];
      e.data = 32'hA0 + i;
      sb_q.push_back(e);
      tick();
      chk($sformatf("rr_grant_%0d", i), {32'd0, ctl_addr}, rr_exp[i] ? 64'h20 : 64'h10);
      ctl_valid = 1'b1;
      ctl_rdata = 32'hA0 + i;
      tick();
      ctl_valid = 1'b0;
      if (rr_exp[i]) ic_rdreq = 1'b0;
      else dc_rdreq = 1'b0;
      tick();
      dc_rdreq = 1'b1;
      ic_rdreq = 1'b1;
    end
    dc_rdreq = 1'b0;
    ic_rdreq = 1'b0;
    tick();

    // dcache read, controller answers at cycle 4
    dc_rdreq = 1'b1;
    dc_addr  = 32'h100;
    e.ic     = 1'b0;
    e.data   = 32'hDEAD_BEEF;
    sb_q.push_back(e);
    for (int cyc = 0; cyc <= 6; cyc++) begin
      chk($sformatf("seq_rdreq_c%0d", cyc), {63'd0, ctl_rdreq}, {63'd0, (cyc >= 1 && cyc <= 4)});
      chk($sformatf("seq_dcvalid_c%0d", cyc), {63'd0, dc_valid}, {63'd0, (cyc == 5)});
      if (cyc == 1) chk("seq_ctl_addr", {32'd0, ctl_addr}, 64'h100);
      if (cyc == 5) begin
        chk("seq_dc_rdata", {32'd0, dc_rdata}, 64'hDEAD_BEEF);
        dc_rdreq = 1'b0;
      end
      ctl_valid = (cyc == 4);
      ctl_rdata = (cyc == 4) ? 32'hDEAD_BEEF : 32'h0;
      tick();
    end
    ctl_valid = 1'b0;

    // table of single-client transactions
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
    end

    // timeout: counter saturates at BUSY cycle 15, transaction still completes
    dc_rdreq = 1'b1;
    dc_addr  = 32'h700;
    e.ic     = 1'b0;
    e.data   = 32'h77;
    sb_q.push_back(e);
    tick();
    for (int k = 0; k < 20; k++) begin
      if (k == 0 || k == 14) chk($sformatf("to_err_low_k%0d", k), {63'd0, err_timeout}, 64'd0);
      if (k == 15 || k == 19) chk($sformatf("to_err_high_k%0d", k), {63'd0, err_timeout}, 64'd1);
      if (k == 19) chk("to_still_busy", {63'd0, ctl_rdreq}, 64'd1);
      tick();
    end
    ctl_valid = 1'b1;
    ctl_rdata = 32'h77;
    tick();
    ctl_valid = 1'b0;
    dc_rdreq  = 1'b0;
    chk("to_req_drop", {62'd0, ctl_rdreq, ctl_wrreq}, 64'd0);
    tick();
    tick();
    chk("to_err_sticky", {63'd0, err_timeout}, 64'd1);

    // reset in the middle of BUSY
    dc_rdreq = 1'b1;
    dc_addr  = 32'h800;
    tick();
    tick();
    chk("mid_busy_req", {63'd0, ctl_rdreq}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_req_drop", {62'd0, ctl_rdreq, ctl_wrreq}, 64'd0);
    chk("async_err_clr", {63'd0, err_timeout}, 64'd0);
    dc_rdreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n       = 1'b1;
    last_dc_rdata = '0;
    last_ic_rdata = '0;
    ctl_valid     = 1'b1;
    ctl_rdata     = 32'h99;
    quiet         = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (dc_valid || ic_valid || ctl_rdreq || ctl_wrreq) quiet = 1'b0;
      tick();
      ctl_valid = 1'b0;
    end
    chk("post_reset_quiet", {63'd0, quiet}, 64'd1);

    // last-grant reset again: dcache wins the first contest
    dc_addr  = 32'h30;
    ic_addr  = 32'h40;
    dc_rdreq = 1'b1;
    ic_rdreq = 1'b1;
    e.ic     = 1'b0;
    e.data   = 32'hB0;
    sb_q.push_back(e);
    tick();
    chk("rr_after_reset", {32'd0, ctl_addr}, 64'h30);
    ctl_valid = 1'b1;
    ctl_rdata = 32'hB0;
    tick();
    ctl_valid = 1'b0;
    dc_rdreq  = 1'b0;
    ic_rdreq  = 1'b0;
    tick();
    tick();
    tick();

    chk("sb_drained", sb_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
